// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result sequencer: function codes,
// FSM state encoding and small decode helpers.
package alu_pkg;

    localparam int unsigned FUNC_W = 3;

    localparam logic [FUNC_W-1:0] FUNC_ADD   = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_SUB   = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_AND   = 3'b010;
    localparam logic [FUNC_W-1:0] FUNC_OR    = 3'b011;
    localparam logic [FUNC_W-1:0] FUNC_PASSB = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the arithmetic codes produce a meaningful carry/overflow
    function automatic logic is_arith(input logic [FUNC_W-1:0] func);
        return (func == FUNC_ADD) || (func == FUNC_SUB);
    endfunction

    // Signed overflow from operand/result sign bits; sub selects SUB rules
    function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        if (sub) begin
            return (a_msb != b_msb) && (r_msb != a_msb);
        end
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Condition flag register (C/Z/N, plus V when ALU_SEQ_OVERFLOW_EN is defined)
// with separate load-path and ALU-writeback update sources.
module alu_flag_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             alu_en,
    input  logic             c_en,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
`ifdef ALU_SEQ_OVERFLOW_EN
    input  logic             alu_v,
    output logic             flag_v,
`endif
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n
);

    // C/Z/N update: load computes Z/N from the value, writeback takes ALU flags
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (load_en) begin
                flag_z <= (load_val == '0);
                flag_n <= load_val[WIDTH-1];
            end else if (alu_en) begin
                flag_z <= alu_z;
                flag_n <= alu_n;
            end
            if (alu_en && c_en) begin
                flag_c <= alu_c;
            end
        end
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    // Overflow is only touched by ADD/SUB writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_v <= 1'b0;
        end else if (alu_en && c_en) begin
            flag_v <= alu_v;
        end
    end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle operand feeder and result/flag register around an external
// combinational ALU. One request at a time over valid/ready; ALU inputs are
// held EXEC_CYCLES cycles (>= 1) before the result is written back.
// Optional: define ALU_SEQ_OVERFLOW_EN to add the flag_v signed-overflow flag.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func,
    input  logic [WIDTH-1:0] req_operand,
    input  logic             req_load,
    input  logic             req_cin_sel,
    output logic [WIDTH-1:0] alu_inputA,
    output logic [WIDTH-1:0] alu_inputB,
    output logic             alu_carryIn,
    output logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryOut,
    input  logic             alu_zero,
    input  logic             alu_negetive,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic             flag_v,
`endif
    output logic             done
);

    localparam int unsigned CNT_W = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   operand_q;
    logic [2:0]         func_q;
    logic               cin_sel_q;
    logic               accept;
    logic               wb_alu;
    logic               wb_load;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign wb_alu    = (state == EXEC) && (cnt == CNT_W'(1));
    assign wb_load   = accept && req_load;

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign alu_inputA  = acc;
    assign alu_inputB  = operand_q;
    assign alu_func    = func_q;
    assign alu_carryIn = cin_sel_q ? flag_c : 1'b0;

    // Sequencer FSM with accumulator and registered ALU operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            operand_q <= '0;
            func_q    <= '0;
            cin_sel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_load) begin
                            acc   <= req_operand;
                            state <= DONE;
                        end else begin
                            operand_q <= req_operand;
                            func_q    <= req_func;
                            cin_sel_q <= req_cin_sel;
                            cnt       <= CNT_W'(EXEC_CYCLES);
                            state     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        acc   <= alu_result;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_c;
    assign ovf_c = signed_ovf(func_q == FUNC_SUB, acc[WIDTH-1],
                              operand_q[WIDTH-1], alu_result[WIDTH-1]);
`endif

    alu_flag_reg #(
        .WIDTH (WIDTH)
    ) u_flags (
        .clk      (clk),
        .rst      (rst),
        .load_en  (wb_load),
        .load_val (req_operand),
        .alu_en   (wb_alu),
        .c_en     (is_arith(func_q)),
        .alu_c    (alu_carryOut),
        .alu_z    (alu_zero),
        .alu_n    (alu_negetive),
`ifdef ALU_SEQ_OVERFLOW_EN
        .alu_v    (ovf_c),
        .flag_v   (flag_v),
`endif
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .flag_n   (flag_n)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a table of requests with expected results feeds
// a done-driven scoreboard (EXEC_CYCLES = 1 instance), plus hand sequences for
// handshake back-pressure and mid-operation reset (EXEC_CYCLES = 3 instance).
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
    } alu_out_t;

    typedef struct {
        logic       load;
        logic [2:0] func;
        logic [7:0] op;
        logic       cin;
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    // Reference combinational ALU; SUB carry-out is the borrow
    function automatic alu_out_t alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic [2:0] f);
        logic [8:0] t;
        alu_out_t   o;
        case (f)
            FUNC_ADD:   t = {1'b0, a} + {1'b0, b} + 9'(cin);
            FUNC_SUB:   t = {1'b0, a} - {1'b0, b} - 9'(cin);
            FUNC_AND:   t = {1'b0, a & b};
            FUNC_OR:    t = {1'b0, a | b};
            FUNC_PASSB: t = {1'b0, b};
            default:    t = {1'b0, a ^ b};
        endcase
        o.r = t[7:0];
        o.c = t[8];
        o.z = (t[7:0] == 8'h00);
        o.n = t[7];
        return o;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // EXEC_CYCLES = 1 instance
    logic       rst1, d1_valid, d1_ready, d1_load, d1_cin;
    logic [2:0] d1_func, d1_alu_func;
    logic [7:0] d1_op, d1_alu_a, d1_alu_b, d1_acc;
    logic       d1_alu_cin, d1_c, d1_z, d1_n, d1_busy, d1_done;
    alu_out_t   a1;
    always_comb a1 = alu_f(d1_alu_a, d1_alu_b, d1_alu_cin, d1_alu_func);

    // EXEC_CYCLES = 3 instance
    logic       rst3, d3_valid, d3_ready, d3_load, d3_cin;
    logic [2:0] d3_func, d3_alu_func;
    logic [7:0] d3_op, d3_alu_a, d3_alu_b, d3_acc;
    logic       d3_alu_cin, d3_c, d3_z, d3_n, d3_busy, d3_done;
    alu_out_t   a3;
    always_comb a3 = alu_f(d3_alu_a, d3_alu_b, d3_alu_cin, d3_alu_func);

`ifdef ALU_SEQ_OVERFLOW_EN
    logic d1_v, d3_v;
`endif

    alu_op_sequencer #(.WIDTH(8), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req_valid(d1_valid), .req_ready(d1_ready),
        .req_func(d1_func), .req_operand(d1_op), .req_load(d1_load),
        .req_cin_sel(d1_cin), .alu_inputA(d1_alu_a), .alu_inputB(d1_alu_b),
        .alu_carryIn(d1_alu_cin), .alu_func(d1_alu_func), .alu_result(a1.r),
        .alu_carryOut(a1.c), .alu_zero(a1.z), .alu_negetive(a1.n),
        .acc(d1_acc), .flag_c(d1_c), .flag_z(d1_z), .flag_n(d1_n),
        .busy(d1_busy),
`ifdef ALU_SEQ_OVERFLOW_EN
        .flag_v(d1_v),
`endif
        .done(d1_done)
    );

    alu_op_sequencer #(.WIDTH(8), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(d3_valid), .req_ready(d3_ready),
        .req_func(d3_func), .req_operand(d3_op), .req_load(d3_load),
        .req_cin_sel(d3_cin), .alu_inputA(d3_alu_a), .alu_inputB(d3_alu_b),
        .alu_carryIn(d3_alu_cin), .alu_func(d3_alu_func), .alu_result(a3.r),
        .alu_carryOut(a3.c), .alu_zero(a3.z), .alu_negetive(a3.n),
        .acc(d3_acc), .flag_c(d3_c), .flag_z(d3_z), .flag_n(d3_n),
        .busy(d3_busy),
`ifdef ALU_SEQ_OVERFLOW_EN
        .flag_v(d3_v),
`endif
        .done(d3_done)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   d3_dones = 0;
    vec_t exp_q[$];
    vec_t tbl[14];
    logic [7:0] prev_acc = 8'h00;
    logic       prev_c   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each done pulse retires the oldest expected result
    always @(negedge clk) begin : mon
        vec_t e;
        if (d1_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done with empty queue", 32'(d1_done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("wb acc", 32'(d1_acc), 32'(e.acc));
                check("wb flag_c", 32'(d1_c), 32'(e.c));
                check("wb flag_z", 32'(d1_z), 32'(e.z));
                check("wb flag_n", 32'(d1_n), 32'(e.n));
`ifdef ALU_SEQ_OVERFLOW_EN
                check("wb flag_v", 32'(d1_v), 32'(e.v));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (d3_done === 1'b1) d3_dones = d3_dones + 1;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        @(negedge clk);
        check($sformatf("v%0d ready", idx), 32'(d1_ready), 32'(1));
        d1_valid = 1'b1; d1_load = v.load; d1_func = v.func; d1_op = v.op; d1_cin = v.cin;
        exp_q.push_back(v);
        @(posedge clk); #1;
        d1_valid = 1'b0;
        if (v.load) begin
            check($sformatf("v%0d load done latency", idx), 32'(d1_done), 32'(1));
        end else begin
            check($sformatf("v%0d alu_inputA", idx), 32'(d1_alu_a), 32'(prev_acc));
            check($sformatf("v%0d alu_inputB", idx), 32'(d1_alu_b), 32'(v.op));
            check($sformatf("v%0d alu_func", idx), 32'(d1_alu_func), 32'(v.func));
            check($sformatf("v%0d alu_carryIn", idx), 32'(d1_alu_cin), 32'(v.cin & prev_c));
            k = 0;
            while (d1_done !== 1'b1 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            check($sformatf("v%0d alu done latency", idx), 32'(k), 32'(1));
        end
        prev_acc = v.acc;
        prev_c   = v.c;
        @(posedge clk); #1;
        check($sformatf("v%0d idle after done", idx), 32'(d1_busy), 32'(0));
    endtask

    initial begin
        int lowcnt;
        //         load  func        op     cin   acc    c     z     n     v
        tbl[0]  = '{1'b1, FUNC_ADD,   8'hF9, 1'b0, 8'hF9, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, FUNC_ADD,   8'h84, 1'b0, 8'h7D, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, FUNC_ADD,   8'h0E, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, FUNC_AND,   8'hEE, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, FUNC_ADD,   8'h01, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, FUNC_SUB,   8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, FUNC_SUB,   8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, FUNC_ADD,   8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, FUNC_OR,    8'h80, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, FUNC_PASSB, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'b101,     8'h55, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, FUNC_ADD,   8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, FUNC_ADD,   8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, FUNC_SUB,   8'h03, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

        rst1 = 1'b1; rst3 = 1'b1;
        d1_valid = 1'b0; d1_load = 1'b0; d1_func = 3'd0; d1_op = 8'h00; d1_cin = 1'b0;
        d3_valid = 1'b0; d3_load = 1'b0; d3_func = 3'd0; d3_op = 8'h00; d3_cin = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("ready during reset", 32'(d1_ready), 32'(0));
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        #1;
        check("reset acc", 32'(d1_acc), 32'(8'h00));
        check("reset flags czn", 32'({d1_c, d1_z, d1_n}), 32'(0));
        check("reset busy", 32'(d1_busy), 32'(0));
        check("reset ready", 32'(d1_ready), 32'(1));
        check("reset done", 32'(d1_done), 32'(0));
`ifdef ALU_SEQ_OVERFLOW_EN
        check("reset flag_v", 32'(d1_v), 32'(0));
`endif

        // Table-driven requests
        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

`ifdef ALU_SEQ_OVERFLOW_EN
        // Signed overflow set by ADD, held through a logic op
        begin
            vec_t v;
            v = '{1'b1, FUNC_ADD, 8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
            run_vec(v, 100);
            v = '{1'b0, FUNC_ADD, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
            run_vec(v, 101);
            v = '{1'b0, FUNC_AND, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
            run_vec(v, 102);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'(0));

        // Back-pressure: valid held high across a 3-cycle operation
        @(negedge clk);
        d3_valid = 1'b1; d3_load = 1'b0; d3_func = FUNC_ADD; d3_op = 8'h05; d3_cin = 1'b0;
        @(posedge clk); #1;
        d3_op = 8'h03;
        lowcnt = 0;
        while (d3_ready !== 1'b1 && lowcnt < 20) begin
            lowcnt++;
            @(posedge clk); #1;
        end
        check("ready low cycles", 32'(lowcnt), 32'(4));
        check("dut3 acc after first op", 32'(d3_acc), 32'(8'h05));
        check("dut3 first done", 32'(d3_dones), 32'(1));
        @(posedge clk); #1;
        d3_valid = 1'b0;
        check("dut3 second accepted", 32'(d3_busy), 32'(1));
        repeat (4) @(posedge clk);
        #1;
        check("dut3 acc after second op", 32'(d3_acc), 32'(8'h08));
        check("dut3 idle after second op", 32'(d3_busy), 32'(0));
        check("dut3 second done", 32'(d3_dones), 32'(2));

        // Reset in the middle of EXEC discards the operation
        @(negedge clk);
        d3_valid = 1'b1; d3_op = 8'h10;
        @(posedge clk); #1;
        d3_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk); #1;
        check("mid-exec rst acc", 32'(d3_acc), 32'(8'h00));
        check("mid-exec rst busy", 32'(d3_busy), 32'(0));
        check("mid-exec rst done", 32'(d3_done), 32'(0));
        check("ready while rst", 32'(d3_ready), 32'(0));
        check("mid-exec rst flags", 32'({d3_c, d3_z, d3_n}), 32'(0));
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        check("ready after rst", 32'(d3_ready), 32'(1));
        repeat (5) @(posedge clk);
        #1;
        check("no done after rst", 32'(d3_dones), 32'(2));
        check("stays idle after rst", 32'(d3_busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle operand/result stage wrapped around the existing combinational 8-bit ALU.
- Accepts one operation request at a time over a valid/ready handshake.
- Drives the ALU inputs from a registered accumulator and operand, waits a programmable settle time, then writes back the result and the carry, zero and negative flags.
- Sits directly upstream of the ALU as its operand feeder and directly downstream as its result/flag register.

Parameters:
- WIDTH, 8: datapath width; must match the ALU.
- EXEC_CYCLES, 1: cycles the ALU inputs are held before sampling; minimum 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_func  input  3  ALU function code
- req_operand  input  WIDTH  operand B, or the load value
- req_load  input  1  1 = load req_operand into acc, bypassing the ALU
- req_cin_sel  input  1  ALU carry-in source: 0 = constant 0, 1 = flag_c
- alu_inputA  output  WIDTH  to ALU inputA; always equals acc
- alu_inputB  output  WIDTH  to ALU inputB; registered operand
- alu_carryIn  output  1  to ALU carryIn
- alu_func  output  3  to ALU func; registered
- alu_result  input  WIDTH  from ALU result
- alu_carryOut  input  1  from ALU carryOut
- alu_zero  input  1  from ALU zero
- alu_negetive  input  1  from ALU negetive
- acc  output  WIDTH  accumulator
- flag_c  output  1  carry flag
- flag_z  output  1  zero flag
- flag_n  output  1  negative flag
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-high, on clk: single clock domain, no asynchronous reset.
- On rst: state IDLE, acc 0, all flags 0, done 0, counter 0, operand/func registers 0. Any in-flight operation is discarded and no done is produced. rst has priority over every other event.
- FSM has three states: IDLE, EXEC, DONE.
- req_ready = (state == IDLE) and not rst. A request is accepted on the edge where req_valid and req_ready are both high. req_valid is ignored outside IDLE; there is no queueing.
- Accepted ALU op (req_load = 0):
  - On the accept edge, register operand, func and cin_sel; load the counter with EXEC_CYCLES; go to EXEC.
  - In EXEC, the ALU inputs are stable and the counter decrements each edge.
  - On the edge where the counter reaches 1: acc <= alu_result, flag_z <= alu_zero, flag_n <= alu_negetive; go to DONE.
  - flag_c <= alu_carryOut only when func is ADD or SUB; all other codes preserve flag_c.
- Accepted load (req_load = 1):
  - On the accept edge: acc <= req_operand, flag_z <= (operand == 0), flag_n <= operand MSB, flag_c preserved.
  - Go directly to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency:
  - ALU op: acc is updated EXEC_CYCLES edges after the accept edge; done is high in the following cycle. Initiation interval is EXEC_CYCLES + 2.
  - Load: acc is updated on the accept edge; done is high the next cycle; initiation interval is 2.
- alu_carryIn = req_cin_sel_reg ? flag_c : 0. flag_c is stable during EXEC because flags are written only at writeback.
- Undefined func codes (101–111) are passed to the ALU unchanged: Z and N are written, C is preserved.
- alu_inputA = acc throughout. acc does not change during EXEC.

Optional Feature:
- Macro ALU_SEQ_OVERFLOW_EN.
- Defined: adds output port flag_v (1 bit, reset 0), the signed overflow flag.
  - ADD: V = (A MSB == B MSB) and (result MSB != A MSB).
  - SUB: V = (A MSB != B MSB) and (result MSB != A MSB).
  - Written at ALU writeback for ADD/SUB only; preserved for all other ops and for loads.
- Undefined: no flag_v port and no overflow logic.

Decomposition:
- Shared package alu_pkg holds:
  - Func codes: FUNC_ADD = 3'b000, FUNC_SUB = 3'b001, FUNC_AND = 3'b010, FUNC_OR = 3'b011, FUNC_PASSB = 3'b100.
  - FSM state encoding: IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2.
- One natural sub-module, alu_flag_reg: holds C/Z/N (and V) with per-flag write enables and the load-path Z/N computation.
- The ALU itself stays external and is instanced by the bench/top alongside the sequencer.

Test Plan:
- Reset: assert rst for 2 cycles → acc = 0x00, flags C/Z/N = 0, busy = 0, req_ready = 1, done = 0.
- Load then ADD:
  - Load 0xF9, then ADD operand 0x84 with cin_sel = 0 and EXEC_CYCLES = 1.
  - → alu_inputA = 0xF9 and alu_inputB = 0x84 during EXEC; acc = 0x7D, C = 1, Z = 0, N = 0 at writeback; done exactly 2 cycles after the accept edge.
- Logic op preserves carry: after the previous op (C = 1), load 0x0E, AND 0xEE → acc = 0x0E, C still 1, Z = 0, N = 0.
- Zero result: load 0x01, SUB 0x01 → acc = 0x00, Z = 1, N = 0, C = alu_carryOut as returned by the ALU.
- Handshake and reset:
  - req_valid held high with EXEC_CYCLES = 3 → req_ready low for 4 cycles and the second request is accepted only on return to IDLE.
  - rst pulsed mid-EXEC → next cycle acc = 0x00, IDLE, no done pulse.
- With ALU_SEQ_OVERFLOW_EN: load 0x7F, ADD 0x01 → acc = 0x80, V = 1, N = 1, C = 0; a following AND 0xFF leaves V = 1.
